// File: rtl/last_key.sv
// Reports the index of the most recently pressed key line and whether any key is held.
// A press is a 0->1 edge on a line; when several lines rise together the lowest index wins.
module last_key #(
   parameter int N_KEYS = 24,
   parameter int KEY_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] keys,
   output logic [KEY_W-1:0]  key,
   output logic              press
);

   logic [N_KEYS-1:0] prev_q;
   logic [N_KEYS-1:0] prev_d;
   logic [KEY_W-1:0]  key_q;
   logic [KEY_W-1:0]  key_d;
   logic              press_q;
   logic              press_d;
   logic [N_KEYS-1:0] rise_s;

   // Lowest set bit of vec, scanned from the top so the lowest index is written last.
   function automatic logic [KEY_W-1:0] lowest_idx(input logic [N_KEYS-1:0] vec);
      logic [KEY_W-1:0] idx;
      idx = {KEY_W{1'b0}};
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = KEY_W'(i);
         end
      end
      return idx;
   endfunction

   // Next-state logic: edge detect and newest-press selection.
   always_comb begin
      rise_s  = keys & ~prev_q;
      prev_d  = keys;
      press_d = |keys;
      if (rise_s != {N_KEYS{1'b0}}) begin
         key_d = lowest_idx(rise_s);
      end else begin
         key_d = key_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= {N_KEYS{1'b0}};
         key_q   <= {KEY_W{1'b0}};
         press_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         key_q   <= key_d;
         press_q <= press_d;
      end
   end

   assign key   = key_q;
   assign press = press_q;

endmodule

// File: tb/tb_last_key.sv
// Directed and randomised self-checking bench for last_key.
module tb_last_key;

   logic        clk;
   logic        rst;
   logic [23:0] keys;
   logic [4:0]  key;
   logic        press;

   int total;
   int bad;

   last_key #(.N_KEYS(24), .KEY_W(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .keys  (keys),
      .key   (key),
      .press (press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply v at a falling edge, then let n rising edges pass and settle 1 time unit.
   task automatic drive(input logic [23:0] v, input int n);
      @(negedge clk);
      keys = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst  = 1'b1;
      keys = 24'h000000;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (key !== 5'd0 || press !== 1'b0) begin
         bad++;
         $display("FAIL reset: key=%0d press=%0b, expected key=0 press=0", key, press);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_sequence;
      logic [23:0] v  [6];
      logic [4:0]  ek [6];
      logic        ep [6];
      v[0] = 24'h000000; ek[0] = 5'd0;  ep[0] = 1'b0;
      v[1] = 24'h000001; ek[1] = 5'd0;  ep[1] = 1'b1;
      v[2] = 24'h000011; ek[2] = 5'd4;  ep[2] = 1'b1;
      v[3] = 24'h000003; ek[3] = 5'd1;  ep[3] = 1'b1;
      v[4] = 24'h800000; ek[4] = 5'd23; ep[4] = 1'b1;
      v[5] = 24'h000000; ek[5] = 5'd23; ep[5] = 1'b0;
      for (int s = 0; s < 6; s++) begin
         drive(v[s], 1);
         total++;
         if (key !== ek[s] || press !== ep[s]) begin
            bad++;
            $display("FAIL seq_first step%0d: key=%0d press=%0b, expected key=%0d press=%0b",
                     s, key, press, ek[s], ep[s]);
         end
         repeat (4) @(posedge clk);
         #1;
         total++;
         if (key !== ek[s] || press !== ep[s]) begin
            bad++;
            $display("FAIL seq_hold step%0d: key=%0d press=%0b, expected key=%0d press=%0b",
                     s, key, press, ek[s], ep[s]);
         end
      end
   endtask

   task automatic test_simultaneous;
      drive(24'h000000, 2);
      drive(24'h000840, 1);
      total++;
      if (key !== 5'd6 || press !== 1'b1) begin
         bad++;
         $display("FAIL simul_press: key=%0d press=%0b, expected key=6 press=1", key, press);
      end
      drive(24'h000800, 3);
      total++;
      if (key !== 5'd6 || press !== 1'b1) begin
         bad++;
         $display("FAIL simul_release: key=%0d press=%0b, expected key=6 press=1", key, press);
      end
   endtask

   task automatic test_newest_released;
      drive(24'h000004, 2);
      total++;
      if (key !== 5'd2 || press !== 1'b1) begin
         bad++;
         $display("FAIL newest_first: key=%0d press=%0b, expected key=2 press=1", key, press);
      end
      drive(24'h000024, 2);
      total++;
      if (key !== 5'd5 || press !== 1'b1) begin
         bad++;
         $display("FAIL newest_second: key=%0d press=%0b, expected key=5 press=1", key, press);
      end
      drive(24'h000004, 1);
      for (int c = 0; c < 4; c++) begin
         total++;
         if (key !== 5'd5 || press !== 1'b1) begin
            bad++;
            $display("FAIL newest_release c%0d: key=%0d press=%0b, expected key=5 press=1",
                     c, key, press);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid;
      drive(24'h000200, 3);
      total++;
      if (key !== 5'd9 || press !== 1'b1) begin
         bad++;
         $display("FAIL rmid_before: key=%0d press=%0b, expected key=9 press=1", key, press);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (key !== 5'd0 || press !== 1'b0) begin
         bad++;
         $display("FAIL rmid_during: key=%0d press=%0b, expected key=0 press=0", key, press);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (key !== 5'd9 || press !== 1'b1) begin
         bad++;
         $display("FAIL rmid_after: key=%0d press=%0b, expected key=9 press=1", key, press);
      end
   endtask

   task automatic test_random_latency;
      logic [23:0] m_prev;
      logic [4:0]  m_key;
      logic        m_press;
      logic [23:0] r;
      logic [23:0] onehot;
      int          nbad;
      nbad = 0;
      // Bring DUT and model into the same known state.
      @(negedge clk);
      keys = 24'h000000;
      rst  = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_prev  = 24'h000000;
      m_key   = 5'd0;
      m_press = 1'b0;
      for (int it = 0; it < 1000; it++) begin
         @(negedge clk);
         #4;
         keys = $urandom() & 32'h00FFFFFF;
         #0;
         total++;
         if (key !== m_key || press !== m_press) begin
            bad++;
            nbad++;
            if (nbad < 10)
               $display("FAIL lat_before it%0d: key=%0d press=%0b, expected key=%0d press=%0b",
                        it, key, press, m_key, m_press);
         end
         r      = keys & ~m_prev;
         onehot = r & (~r + 24'd1);
         if (r != 24'h000000) m_key = 5'($clog2(onehot));
         m_press = (keys != 24'h000000);
         m_prev  = keys;
         @(posedge clk);
         #1;
         total++;
         if (key !== m_key || press !== m_press) begin
            bad++;
            nbad++;
            if (nbad < 10)
               $display("FAIL lat_after it%0d keys=%06h: key=%0d press=%0b, expected key=%0d press=%0b",
                        it, keys, key, press, m_key, m_press);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      keys  = 24'h000000;
      test_reset();
      test_sequence();
      test_simultaneous();
      test_newest_released();
      test_reset_mid();
      test_random_latency();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
